array_result_drain: RTL and testbench
=====================================

Name: array_result_drain

Overview:
- Consumer end of the systolic array's `activated` window.
- Captures one array output row per activated cycle into a small FIFO, then streams the rows out over a valid/ready interface.
- Drives `stall` back to the array and activate timer when the buffer cannot accept more data.
- Signals `done` once every row of a job has been delivered downstream.

Parameters:
- LANES, 4, number of array columns; one 16-bit result per lane per row
- LANE_W, 16, bits per lane result (two's complement)
- DEPTH, 8, FIFO entries; power of 2, minimum 2
- STALL_TH, 1, stall asserts when free entries <= STALL_TH; range 1..DEPTH-1

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- trigger_array  input  1  job start pulse, the same signal that starts the activate timer
- num_inputs  input  7  rows expected for this job; sampled on trigger_array
- activated  input  1  array row valid this cycle, already gated by ~stall
- array_row  input  LANES*LANE_W  array output row; lane 0 in the LSBs
- stall  output  1  backpressure to array and timer
- out_valid  output  1  out_data holds a valid row
- out_ready  input  1  downstream accepts the row
- out_data  output  LANES*LANE_W  head-of-FIFO row
- done  output  1  one-cycle pulse when the job is fully drained
- err  output  1  sticky protocol error flag

Behaviour:
- Reset state: all outputs 0, FIFO empty, FSM in IDLE, all counters 0. Reset mid-operation discards buffered data.
- FSM states:
  - IDLE:
    - trigger_array=1 -> latch num_inputs into `expected`; clear `captured`; go to COLLECT.
    - If latched num_inputs==0, go to FINISH instead.
  - COLLECT:
    - On each cycle with activated=1, push array_row and increment `captured`.
    - When the push makes captured==expected, go to DRAIN on the next edge.
  - DRAIN: when the FIFO is empty and no pop is pending, go to FINISH.
  - FINISH: assert done for exactly 1 cycle, then go to IDLE.
- FIFO:
  - Push = activated && state==COLLECT.
  - Pop = out_valid && out_ready.
  - Push and pop in the same cycle are legal, including when the FIFO is full; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits wide.
- Output handshake:
  - out_valid = FIFO not empty.
  - out_data = head entry, driven combinationally from storage; zero added latency.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Latency: a row pushed at edge N is visible on out_data after edge N, provided the FIFO was empty before the push.
- stall:
  - stall = (DEPTH - occupancy) <= STALL_TH, computed from registered occupancy; no combinational path from out_ready.
  - Also forced to 1 in DRAIN and FINISH so the array holds.
  - Forced to 0 in IDLE.
- err is set (sticky until reset) by any of:
  - activated=1 while not in COLLECT;
  - push while the FIFO is full (the row is dropped);
  - trigger_array=1 while not in IDLE (the trigger is ignored).
- Boundary: num_inputs=127 is legal. `captured` is 7 bits and compares equal before it can wrap.

Optional Feature:
- Macro: RESULT_RELU_EN.
- Defined:
  - Each lane is passed through ReLU before the FIFO write: negative values (MSB=1) become 0.
  - Applied per lane, independently; combinational, so latency is unchanged.
- Undefined: rows are stored and emitted bit-exact.

Test Plan:
- Basic job:
  - Stimulus: num_inputs=4, trigger; 4 activated cycles with rows 0x0001_0002_0003_0004 +i; out_ready=1.
  - Required: 4 rows out, in order, matching; done pulses once; err=0.
- Backpressure:
  - Stimulus: DEPTH=8, STALL_TH=1, out_ready=0, num_inputs=10.
  - Required: stall rises once occupancy reaches 7; no more than 7 pushes; after out_ready=1, all 10 rows are delivered in order; err=0.
- Hold under stall:
  - Stimulus: out_ready toggles 1/0 every cycle.
  - Required: out_data stable whenever out_valid=1 and out_ready=0; no row duplicated or lost.
- Simultaneous push/pop while full:
  - Stimulus: FIFO full, activated=1 (with stall forced low by the bench) and out_ready=1 in the same cycle.
  - Required: occupancy stays 8; both rows are correct.
- Protocol errors and empty job:
  - Stimulus: activated while IDLE; separately, num_inputs=0 then trigger.
  - Required: err=1 sticky; the zero-row job gives done two cycles after trigger with out_valid never 1.
- Reset mid-job:
  - Stimulus: assert n_rst low with 3 rows buffered.
  - Required: out_valid=0, stall=0, done=0, err=0 immediately (asynchronous).
  - Required: the next job runs normally.
  - With RESULT_RELU_EN: lane value 0xFFF0 is emitted as 0x0000; lane value 0x0010 passes unchanged.

Source files
------------

// File: rtl/array_result_drain.sv
// Captures systolic-array result rows during the activated window and streams them out over valid/ready.
// Latency: a row pushed into an empty buffer appears on out_data right after the capturing edge; done is registered.
// Backpressure: stall goes high when free entries <= STALL_TH, and also in DRAIN/FINISH; out_ready only drains the buffer.
//
// Ports:
//   clk, n_rst       - rising-edge clock, asynchronous active-low reset
//   trigger_array    - job start pulse; num_inputs is sampled with it
//   num_inputs       - rows expected for the job (0..127)
//   activated        - array row valid this cycle (already gated by ~stall)
//   array_row        - array output row, lane 0 in the LSBs
//   stall            - hold request to the array and activate timer
//   out_valid/out_ready/out_data - downstream row stream, head of buffer
//   done             - one-cycle pulse once every row of the job has left
//   err              - sticky protocol error flag
//
// Optional build macro RESULT_RELU_EN: clamp negative lane values to zero before buffering.

module array_result_drain #(
    parameter int LANES    = 4,
    parameter int LANE_W   = 16,
    parameter int DEPTH    = 8,
    parameter int STALL_TH = 1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      trigger_array,
    input  logic [6:0]                num_inputs,
    input  logic                      activated,
    input  logic [LANES*LANE_W-1:0]   array_row,
    output logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic                      done,
    output logic                      err
);

    localparam int ROW_W = LANES * LANE_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TH_C    = CW'(STALL_TH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [6:0]        expected_q;
    logic [6:0]        captured_q;

    logic [ROW_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic [ROW_W-1:0]  row_in;
    logic              push_req;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     free_cnt;
    logic              last_push;
    logic              err_set;
    logic              done_d;

    // ------------------------------------------------------------------
    // Row conditioning before the buffer write
    // ------------------------------------------------------------------
    always_comb begin
        row_in = array_row;
`ifdef RESULT_RELU_EN
        // Per-lane ReLU: a set sign bit clamps that lane to zero.
        for (int i = 0; i < LANES; i++) begin
            if (array_row[i*LANE_W + LANE_W - 1]) begin
                row_in[i*LANE_W +: LANE_W] = '0;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign free_cnt  = DEPTH_C - count_q;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr_q];

    assign push_req  = activated && (state_q == COLLECT);
    assign pop       = out_valid && out_ready;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign wr_en     = push_req && (~full || pop);
    assign drop      = push_req && full && ~pop;
    assign last_push = push_req && ((captured_q + 7'd1) == expected_q);

    assign err_set   = (activated && (state_q != COLLECT))
                     || drop
                     || (trigger_array && (state_q != IDLE));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= row_in;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (trigger_array) begin
                    state_d = (num_inputs == 7'd0) ? FINISH : COLLECT;
                end
            end
            COLLECT: begin
                // Registered occupancy only: out_ready never reaches stall.
                stall = (free_cnt <= TH_C);
                if (last_push) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (empty) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                stall   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job counters, done pulse and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            expected_q <= '0;
            captured_q <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if ((state_q == IDLE) && trigger_array) begin
                expected_q <= num_inputs;
                captured_q <= '0;
            end else if (push_req) begin
                captured_q <= captured_q + 7'd1;
            end
            // FINISH lasts exactly one cycle, so this is a single-cycle pulse.
            done <= done_d;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_array_result_drain.sv
module tb_array_result_drain;

    logic        clk;
    logic        n_rst;
    logic        trigger_array;
    logic [6:0]  num_inputs;
    logic        activated;
    logic [63:0] array_row;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        done;
    logic        err;

    int          n_checks;
    int          n_errs;
    int          done_cnt;
    logic [63:0] exp_q[$];

    localparam logic [63:0] BASE    = 64'h0001_0002_0003_0004;
    localparam logic [63:0] SIGNROW = 64'hFFF0_0010_8000_7FFF;
`ifdef RESULT_RELU_EN
    localparam logic [63:0] SIGNEXP = 64'h0000_0010_0000_7FFF;
`else
    localparam logic [63:0] SIGNEXP = 64'hFFF0_0010_8000_7FFF;
`endif

    array_result_drain #(
        .LANES    (4),
        .LANE_W   (16),
        .DEPTH    (8),
        .STALL_TH (1)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .trigger_array (trigger_array),
        .num_inputs    (num_inputs),
        .activated     (activated),
        .array_row     (array_row),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model_row(input logic [63:0] r);
        logic [63:0] m;
        m = r;
`ifdef RESULT_RELU_EN
        for (int i = 0; i < 4; i++) begin
            if (r[16*i + 15]) m[16*i +: 16] = 16'h0000;
        end
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Settle the scoreboard for the coming edge, then advance one cycle.
    task automatic tick();
        logic [63:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", out_data, 64'hx);
            end else begin
                e = exp_q.pop_front();
                check("row", out_data, e);
            end
        end
        if (activated) exp_q.push_back(model_row(array_row));
        @(posedge clk);
        #1;
        if (done) done_cnt++;
    endtask

    task automatic start_job(input int n);
        done_cnt      = 0;
        num_inputs    = 7'(n);
        trigger_array = 1'b1;
        activated     = 1'b0;
        tick();
        trigger_array = 1'b0;
    endtask

    // mode 0: always ready; 1: ready toggles; 2: not ready for 20 cycles, then ready.
    task automatic finish_job(input int n, input int sent0, input logic [63:0] base, input int mode);
        int          sent;
        int          cyc;
        logic [63:0] held;
        logic        hold_v;
        sent   = sent0;
        cyc    = 0;
        hold_v = 1'b0;
        held   = '0;
        while (done_cnt == 0 && cyc < 400) begin
            case (mode)
                1:       out_ready = cyc[0];
                2:       out_ready = (cyc >= 20);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && cyc == 20) begin
                check("bp_pushes", 64'(sent), 64'd7);
                check("bp_stall", stall, 1'b1);
            end
            if (hold_v && out_valid) check("hold_data", out_data, held);
            hold_v    = out_valid && !out_ready;
            held      = out_data;
            activated = (sent < n) && !stall;
            array_row = base + 64'(sent);
            tick();
            if (activated) sent++;
            cyc++;
        end
        activated = 1'b0;
        check("done_seen", 64'(done_cnt), 64'd1);
        check("rows_sent", 64'(sent), 64'(n));
        tick();
        check("done_pulse", done, 1'b0);
        check("drained", 64'(exp_q.size()), 64'd0);
        check("job_err", err, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [63:0] base, input int mode);
        out_ready = 1'b0;
        start_job(n);
        finish_job(n, 0, base, mode);
    endtask

    initial begin
        n_checks      = 0;
        n_errs        = 0;
        done_cnt      = 0;
        n_rst         = 1'b0;
        trigger_array = 1'b0;
        num_inputs    = '0;
        activated     = 1'b0;
        array_row     = '0;
        out_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        n_rst = 1'b1;
        tick();

        // Basic four-row job
        run_job(4, BASE, 0);

        // Latency and sign handling on a single row
        start_job(1);
        out_ready = 1'b0;
        activated = 1'b1;
        array_row = SIGNROW;
        tick();
        activated = 1'b0;
        check("lat_valid", out_valid, 1'b1);
        check("sign_row", out_data, SIGNEXP);
        finish_job(1, 1, SIGNROW, 0);

        // Backpressure: stall at occupancy 7, then drain all ten
        run_job(10, BASE + 64'h100, 2);

        // Ready toggling every cycle
        run_job(9, BASE + 64'h200, 1);

        // Fill to 8 with stall overridden, then push and pop together while full
        start_job(12);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            activated = 1'b1;
            array_row = BASE + 64'h300 + 64'(i);
            tick();
        end
        check("full_stall", stall, 1'b1);
        check("full_valid", out_valid, 1'b1);
        check("full_err", err, 1'b0);
        activated = 1'b1;
        array_row = BASE + 64'h300 + 64'd8;
        out_ready = 1'b1;
        tick();
        activated = 1'b0;
        check("pushpop_err", err, 1'b0);
        check("pushpop_stall", stall, 1'b1);
        finish_job(12, 9, BASE + 64'h300, 0);

        // Largest legal job
        run_job(127, 64'h1234_0000_0000_0000, 0);

        // activated while idle is a sticky error
        activated = 1'b1;
        array_row = 64'hDEAD;
        tick();
        activated = 1'b0;
        check("idle_act_err", err, 1'b1);
        tick();
        check("err_sticky", err, 1'b1);
        exp_q.delete();

        // Zero-row job
        num_inputs    = 7'd0;
        trigger_array = 1'b1;
        tick();
        trigger_array = 1'b0;
        check("zero_done_c1", done, 1'b0);
        check("zero_valid_c1", out_valid, 1'b0);
        tick();
        check("zero_done_c2", done, 1'b1);
        check("zero_valid_c2", out_valid, 1'b0);
        tick();
        check("zero_done_c3", done, 1'b0);
        check("zero_valid_c3", out_valid, 1'b0);

        // Reset in the middle of a job with three rows buffered
        start_job(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            activated = 1'b1;
            array_row = BASE + 64'h400 + 64'(i);
            tick();
        end
        activated = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #1;
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        exp_q.delete();
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        run_job(4, BASE + 64'h500, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
